// File: rtl/fact_unit.sv
// rtl/fact_unit.sv - memory-mapped iterative factorial accelerator
// Optional IRQ_EN bit and irq output are built only when FACT_IRQ_EN is defined.
module fact_unit #(
  parameter int unsigned MAX_N = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q;
  logic [3:0]  n_q;
  logic [3:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        err_q;
  logic        irq_en;

  logic        wr_ctrl, wr_n, wr_status, go, n_ok;
  logic [31:0] acc_d;

  assign wr_ctrl   = we && (addr[3:2] == 2'd0);
  assign wr_n      = we && (addr[3:2] == 2'd1);
  assign wr_status = we && (addr[3:2] == 2'd2);
  assign go        = wr_ctrl && wdata[0];
  assign n_ok      = ({28'd0, n_q} <= MAX_N);
  assign acc_d     = acc_q * {28'd0, cnt_q};

`ifdef FACT_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_q <= wdata[1];
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = done_q & irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= 4'd0;
      cnt_q    <= 4'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_n) begin
        n_q <= wdata[3:0];
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            result_q <= 32'd0;
            if (n_ok) begin
              state_q <= S_BUSY;
              cnt_q   <= n_q;
              acc_q   <= 32'd1;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end else if (wr_status) begin
            if (wdata[0]) begin
              done_q  <= 1'b0;
              state_q <= S_IDLE;
            end
            if (wdata[1]) begin
              err_q <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          // GO is ignored here; the computation runs on the latched cnt_q.
          if (cnt_q <= 4'd1) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      2'd0:    rdata = {30'd0, irq_en, 1'b0};
      2'd1:    rdata = {28'd0, n_q};
      2'd2:    rdata = {29'd0, (state_q == S_BUSY), err_q, done_q};
      default: rdata = result_q;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:4]};

endmodule

// File: tb/tb_fact_unit.sv
// tb/tb_fact_unit.sv - self-checking bench for fact_unit
// Checks irq/IRQ_EN behaviour according to whether FACT_IRQ_EN is defined.
module tb_fact_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [31:0] result;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [3:0] n;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  fact_unit #(.MAX_N(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = {28'd0, a, 2'b00};
    wdata = d;
    @(negedge clk);
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = {28'd0, a, 2'b00};
    #1;
    d = rdata;
  endtask

  task automatic wait_done(output int k);
    logic [31:0] s;
    k = 0;
    rd(2'd2, s);
    while (!s[0] && k < 40) begin
      @(negedge clk);
      k++;
      rd(2'd2, s);
    end
  endtask

  task automatic finish_and_check(input string nm, input int lat_offset);
    exp_t        e;
    int          k;
    logic [31:0] d;
    wait_done(k);
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_latency"}, 32'(k), 32'(e.lat - lat_offset));
    rd(2'd3, d);
    chk({nm, "_result"}, d, e.result);
    rd(2'd2, d);
    chk({nm, "_status"}, d, {30'd0, e.err, 1'b1});
  endtask

  task automatic run_go(input logic [3:0] n, input exp_t e, input logic ien);
    logic [31:0] d;
    sb.push_back(e);
    wr(2'd1, {28'd0, n});
    wr(2'd0, {30'd0, ien, 1'b1});
    if (!e.err) begin
      rd(2'd2, d);
      chk("busy_after_go", {29'd0, d[2:0]}, 32'h4);
    end
    finish_and_check($sformatf("n%0d", n), 0);
  endtask

  initial begin
    logic [31:0] d;
    int          k;

    vecs[0] = '{4'd5,  '{32'd120,      1'b0, 5}};
    vecs[1] = '{4'd0,  '{32'd1,        1'b0, 1}};
    vecs[2] = '{4'd1,  '{32'd1,        1'b0, 1}};
    vecs[3] = '{4'd12, '{32'h1C8CFC00, 1'b0, 12}};
    vecs[4] = '{4'd13, '{32'd0,        1'b1, 0}};
    vecs[5] = '{4'd7,  '{32'd5040,     1'b0, 7}};
    vecs[6] = '{4'd15, '{32'd0,        1'b1, 0}};
    vecs[7] = '{4'd2,  '{32'd2,        1'b0, 2}};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      chk($sformatf("reset_reg%0d", i), d, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_go(vecs[i].n, vecs[i].e, 1'b0);
      chk("irq_disabled", {31'd0, irq}, 32'd0);
      wr(2'd2, 32'h3);
      rd(2'd2, d);
      chk("status_w1c", d, 32'd0);
    end

    // Result register holds until the next accepted GO.
    rd(2'd3, d);
    chk("result_hold", d, 32'd2);

    // Abort a running N=10 with reset, then restart.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      chk($sformatf("midreset_reg%0d", i), d, 32'd0);
    end
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_go(4'd4, '{32'd24, 1'b0, 4}, 1'b0);
    wr(2'd2, 32'h1);

    // GO while BUSY is ignored; N write still lands in the register.
    sb.push_back('{32'd720, 1'b0, 6});
    wr(2'd1, 32'd6);
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd1);
    finish_and_check("rego", 2);
    rd(2'd1, d);
    chk("n_updated_busy", d, 32'd3);
    wr(2'd2, 32'h1);
    rd(2'd2, d);
    chk("done_cleared", d, 32'd0);

`ifdef FACT_IRQ_EN
    wr(2'd0, 32'h2);
    rd(2'd0, d);
    chk("ctrl_irq_en", d, 32'h2);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    run_go(4'd3, '{32'd6, 1'b0, 3}, 1'b1);
    chk("irq_high", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h1);
    chk("irq_low_after_w1c", {31'd0, irq}, 32'd0);
`else
    wr(2'd0, 32'h2);
    rd(2'd0, d);
    chk("ctrl_reads_zero", d, 32'd0);
    run_go(4'd3, '{32'd6, 1'b0, 3}, 1'b1);
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
    rd(2'd0, d);
    chk("ctrl_still_zero", d, 32'd0);
    wr(2'd2, 32'h1);
`endif

    k = sb.size();
    chk("sb_drained", 32'(k), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
